board_store: RTL and testbench
==============================

// Module: board_store
// PURPOSE
//  Responder side of the board-RAM interface. Holds the 30-row playfield and serves row reads/writes.
//  Detects full rows, and collapses a cleared row by shifting the rows above it down one row per cycle.
//  Drives the board_data array that the piece/collision logic consumes.
//  Sits between the piece/collision block (initiator) and the VGA/draw path (read-only consumer of BOARD_DATA).
// PARAMETERS
//  ROWS       30  number of board rows
//  ROW_BITS   32  bits per row; 16 cells x 2 bits/cell
//  ADDR_W     11  width of RAM_ROW_ADDR; only values < ROWS are valid
// PORTS
//  CLK            in   1            system clock; all state updates on the rising edge
//  RESET          in   1            asynchronous, active-high reset
//  RAM_ROW_ADDR   in   ADDR_W       row index for a read or write
//  RAM_WE         in   1            write strobe; row <= RAM_WRITEDATA
//  RAM_RE         in   1            read strobe
//  RAM_WRITEDATA  in   ROW_BITS     row write data
//  CLEAR_REQ      in   1            request to collapse row CLEAR_ROW
//  CLEAR_ROW      in   5            row to remove, 0..ROWS-1
//  CLEAR_ALL      in   1            zero the entire board
//  RAM_READDATA   out  ROW_BITS     read data
//  RAM_RVALID     out  1            one-cycle pulse; RAM_READDATA is valid
//  BOARD_DATA     out  ROWS x ROW_BITS  registered board image
//  FULL_ROWS      out  ROWS         bit r=1 when every 2-bit cell in row r is nonzero
//  BUSY           out  1            collapse in progress
//  REQ_DROP       out  1            one-cycle pulse; a WE/RE/CLEAR_REQ was ignored
// BEHAVIOUR
//  Reset: all rows 0, RAM_READDATA=0, RAM_RVALID=0, BUSY=0, REQ_DROP=0, FSM=IDLE, FULL_ROWS=0.
//  Read: RE in cycle N with a valid address -> RAM_READDATA=row, RAM_RVALID=1 in cycle N+1.
//   RAM_READDATA holds its value until the next read.
//  Write: WE in cycle N -> the row updates at the edge ending cycle N; visible on BOARD_DATA in N+1.
//  RE and WE in the same cycle, same address: the read returns the old data.
//  Address >= ROWS: the access is ignored and REQ_DROP pulses; a read returns no RVALID.
//  FULL_ROWS: combinational from the stored rows; a cell is occupied if (b[2c] | b[2c+1]).
//  FSM states IDLE, SHIFT, ZERO:
//   IDLE -> SHIFT on CLEAR_REQ with CLEAR_ROW < ROWS; ptr <= CLEAR_ROW; BUSY=1 from the next cycle.
//   SHIFT: row[ptr] <= row[ptr-1]; ptr--. When ptr==1 (after that copy) -> ZERO.
//   CLEAR_ROW==0: go directly to ZERO.
//   ZERO: row[0] <= 0 -> IDLE; BUSY falls the cycle after.
//   A collapse of row k takes k+1 cycles of BUSY.
//  While BUSY: WE, RE and CLEAR_REQ are ignored and REQ_DROP pulses; the initiator must poll BUSY.
//  CLEAR_REQ with CLEAR_ROW >= ROWS: ignored, REQ_DROP pulses.
//  CLEAR_ALL: highest priority in any state. All rows are zeroed in one edge, the FSM goes to IDLE
//   (an in-progress shift is aborted), and same-cycle WE/RE/CLEAR_REQ are dropped without a REQ_DROP pulse.
//  RESET asserted mid-shift: immediate return to the reset state, no partial rows kept.
// CONFIGURATION
//  LINE_COUNT_EN defined:
//   adds output LINES_CLEARED [15:0], reset 0.
//   Increments on each SHIFT/ZERO entry from IDLE; saturates at 16'hFFFF.
//   CLEAR_ALL zeroes it.
//  LINE_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  polytris_pkg:
//   BOARD_ROWS=30, BOARD_COLS=16, CELL_BITS=2
//   typedef logic [31:0] row_t
//   typedef enum {IDLE, SHIFT, ZERO} store_state_e
//   function row_full(row_t) shared with gameboard line checks
//  One sub-module, row_full_detect: per-row reduction, instanced ROWS times via generate.
//  The storage array, FSM and read port stay in board_store.
// TESTING
//  Write row 5=32'h5555_5555, RE row 5 next cycle -> RVALID=1, READDATA=32'h5555_5555 one cycle later.
//  Same-cycle WE+RE row 3 (old 0, new 32'hFFFF_FFFF) -> READDATA=0; BOARD_DATA[3]=32'hFFFF_FFFF after.
//  Rows 27..29 = A,B,C; CLEAR_REQ row 29 ->
//   BUSY high 30 cycles; then row29=B, row28=A, row0=0.
//   FULL_ROWS[29] was 1 before (C=32'h5555_5555), 0 after.
//  Mid-collapse: WE row 10 -> REQ_DROP pulse, row 10 unchanged; CLEAR_ALL -> all rows 0, BUSY=0 next cycle.
//  RE addr 30 -> no RVALID, REQ_DROP=1; RESET mid-SHIFT -> BUSY=0, all rows 0 immediately.
//  LINE_COUNT_EN: 3 clears -> LINES_CLEARED=3; CLEAR_ALL -> 0.

Source files
------------

// File: rtl/polytris_pkg.sv
// Shared board geometry, row type and FSM states for the playfield store and line checks.
package polytris_pkg;

    localparam int BOARD_ROWS = 30;
    localparam int BOARD_COLS = 16;
    localparam int CELL_BITS  = 2;

    typedef logic [31:0] row_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ZERO
    } store_state_e;

    // A row is full when no cell reads as empty (both cell bits zero).
    function automatic logic row_full(row_t r);
        logic full;
        full = 1'b1;
        for (int c = 0; c < BOARD_COLS; c++) begin
            full &= |r[c*CELL_BITS +: CELL_BITS];
        end
        return full;
    endfunction

endpackage

// File: rtl/row_full_detect.sv
// Per-row full-line reduction; one instance per board row.
module row_full_detect
    import polytris_pkg::*;
(
    input  row_t row,
    output logic full
);

    assign full = row_full(row);

endmodule

// File: rtl/board_store.sv
// Playfield RAM responder: row read/write port, full-row detection and row collapse FSM.
// Optional LINE_COUNT_EN adds a saturating LINES_CLEARED counter.
module board_store
    import polytris_pkg::*;
#(
    parameter int ROWS     = BOARD_ROWS,
    parameter int ROW_BITS = 32,
    parameter int ADDR_W   = 11
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [ADDR_W-1:0]   RAM_ROW_ADDR,
    input  logic                RAM_WE,
    input  logic                RAM_RE,
    input  logic [ROW_BITS-1:0] RAM_WRITEDATA,
    input  logic                CLEAR_REQ,
    input  logic [4:0]          CLEAR_ROW,
    input  logic                CLEAR_ALL,
    output logic [ROW_BITS-1:0] RAM_READDATA,
    output logic                RAM_RVALID,
    output logic [ROW_BITS-1:0] BOARD_DATA [ROWS],
    output logic [ROWS-1:0]     FULL_ROWS,
    output logic                BUSY,
    output logic                REQ_DROP
`ifdef LINE_COUNT_EN
    ,
    output logic [15:0]         LINES_CLEARED
`endif
);

    localparam int IDX_W = $clog2(ROWS);

    logic [ROW_BITS-1:0] rows_q [ROWS];
    logic [ROW_BITS-1:0] rows_d [ROWS];
    store_state_e        state_q, state_d;
    logic [4:0]          ptr_q, ptr_d;
    logic [ROW_BITS-1:0] rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                drop_q, drop_d;
    logic [IDX_W-1:0]    idx;
    logic                addr_ok;
    logic                clr_ok;
`ifdef LINE_COUNT_EN
    logic [15:0]         lines_q, lines_d;
`endif

    assign idx     = RAM_ROW_ADDR[IDX_W-1:0];
    assign addr_ok = RAM_ROW_ADDR < ADDR_W'(ROWS);
    assign clr_ok  = {1'b0, CLEAR_ROW} < 6'(ROWS);

    always_comb begin
        rows_d   = rows_q;
        state_d  = state_q;
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        drop_d   = 1'b0;
`ifdef LINE_COUNT_EN
        lines_d  = lines_q;
`endif
        if (CLEAR_ALL) begin
            // Wipe overrides everything; same-cycle requests vanish silently.
            for (int i = 0; i < ROWS; i++) begin
                rows_d[i] = '0;
            end
            state_d = IDLE;
            ptr_d   = '0;
`ifdef LINE_COUNT_EN
            lines_d = '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (RAM_WE) begin
                        if (addr_ok) rows_d[idx] = RAM_WRITEDATA;
                        else         drop_d = 1'b1;
                    end
                    // Reads sample rows_q, so a same-cycle write returns the old row.
                    if (RAM_RE) begin
                        if (addr_ok) begin
                            rdata_d  = rows_q[idx];
                            rvalid_d = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                    if (CLEAR_REQ) begin
                        if (clr_ok) begin
                            ptr_d   = CLEAR_ROW;
                            state_d = (CLEAR_ROW == 5'd0) ? ZERO : SHIFT;
`ifdef LINE_COUNT_EN
                            if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
`endif
                        end else begin
                            drop_d = 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    rows_d[ptr_q] = rows_q[ptr_q - 5'd1];
                    ptr_d         = ptr_q - 5'd1;
                    if (ptr_q == 5'd1) state_d = ZERO;
                    drop_d        = RAM_WE | RAM_RE | CLEAR_REQ;
                end
                ZERO: begin
                    rows_d[0] = '0;
                    state_d   = IDLE;
                    drop_d    = RAM_WE | RAM_RE | CLEAR_REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < ROWS; i++) begin
                rows_q[i] <= '0;
            end
            state_q  <= IDLE;
            ptr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            drop_q   <= 1'b0;
`ifdef LINE_COUNT_EN
            lines_q  <= '0;
`endif
        end else begin
            rows_q   <= rows_d;
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            drop_q   <= drop_d;
`ifdef LINE_COUNT_EN
            lines_q  <= lines_d;
`endif
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_full
        row_full_detect u_full (
            .row  (rows_q[r]),
            .full (FULL_ROWS[r])
        );
    end

    assign BOARD_DATA   = rows_q;
    assign RAM_READDATA = rdata_q;
    assign RAM_RVALID   = rvalid_q;
    assign BUSY         = (state_q != IDLE);
    assign REQ_DROP     = drop_q;
`ifdef LINE_COUNT_EN
    assign LINES_CLEARED = lines_q;
`endif

endmodule

// File: tb/tb_board_store.sv
// Directed self-checking bench for board_store (build with +define+LINE_COUNT_EN to cover the counter).
module tb_board_store;

    logic        clk;
    logic        rst;
    logic [10:0] addr;
    logic        we, re;
    logic [31:0] wdata;
    logic        clear_req;
    logic [4:0]  clear_row;
    logic        clear_all;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] board [30];
    logic [29:0] full_rows;
    logic        busy;
    logic        req_drop;
`ifdef LINE_COUNT_EN
    logic [15:0] lines;
`endif

    int total = 0;
    int bad   = 0;
    int cycles;

    board_store dut (
        .CLK           (clk),
        .RESET         (rst),
        .RAM_ROW_ADDR  (addr),
        .RAM_WE        (we),
        .RAM_RE        (re),
        .RAM_WRITEDATA (wdata),
        .CLEAR_REQ     (clear_req),
        .CLEAR_ROW     (clear_row),
        .CLEAR_ALL     (clear_all),
        .RAM_READDATA  (rdata),
        .RAM_RVALID    (rvalid),
        .BOARD_DATA    (board),
        .FULL_ROWS     (full_rows),
        .BUSY          (busy),
        .REQ_DROP      (req_drop)
`ifdef LINE_COUNT_EN
        ,
        .LINES_CLEARED (lines)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_drop;
        logic [29:0] exp_full;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 0; re = 0; addr = '0; wdata = '0;
        clear_req = 0; clear_row = '0; clear_all = 0;
    endtask

    task automatic write_row(input int r, input logic [31:0] d);
        we = 1; addr = 11'(r); wdata = d;
        cycle();
        we = 0;
    endtask

    function automatic int nonzero_rows();
        int n = 0;
        for (int i = 0; i < 30; i++) if (board[i] != 32'h0) n++;
        return n;
    endfunction

    // Issues a collapse and counts the BUSY cycles that follow (bounded).
    task automatic do_clear(input int r, output int n);
        clear_req = 1; clear_row = 5'(r);
        cycle();
        clear_req = 0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 11'd5,  32'h5555_5555, 1'b0, 32'h0,         1'b0, 30'h20};
        vecs[1] = '{1'b0, 1'b1, 11'd5,  32'h0,         1'b1, 32'h5555_5555, 1'b0, 30'h20};
        vecs[2] = '{1'b1, 1'b1, 11'd3,  32'hFFFF_FFFF, 1'b1, 32'h0,         1'b0, 30'h28};
        vecs[3] = '{1'b0, 1'b1, 11'd3,  32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 30'h28};
        vecs[4] = '{1'b0, 1'b1, 11'd30, 32'h0,         1'b0, 32'hFFFF_FFFF, 1'b1, 30'h28};
        vecs[5] = '{1'b1, 1'b0, 11'd31, 32'h1,         1'b0, 32'hFFFF_FFFF, 1'b1, 30'h28};
        vecs[6] = '{1'b0, 1'b0, 11'd0,  32'h0,         1'b0, 32'hFFFF_FFFF, 1'b0, 30'h28};
        vecs[7] = '{1'b0, 1'b1, 11'd0,  32'h0,         1'b1, 32'h0,         1'b0, 30'h28};

        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;

        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_drop", req_drop, 0);
        chk("rst_full", full_rows, 0);
        chk("rst_rows", nonzero_rows(), 0);
`ifdef LINE_COUNT_EN
        chk("rst_lines", lines, 0);
`endif

        for (int i = 0; i < 8; i++) begin
            we = vecs[i].we; re = vecs[i].re; addr = vecs[i].addr; wdata = vecs[i].wdata;
            cycle();
            chk($sformatf("v%0d_rvalid", i), rvalid, vecs[i].exp_rvalid);
            chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_drop", i), req_drop, vecs[i].exp_drop);
            chk($sformatf("v%0d_full", i), full_rows, vecs[i].exp_full);
        end
        idle_inputs();
        chk("wr_rd_row3", board[3], 32'hFFFF_FFFF);

        // Collapse of row 29 with A,B,C in rows 27..29
        write_row(27, 32'h1234_5678);
        write_row(28, 32'h9ABC_DEF0);
        write_row(29, 32'h5555_5555);
        chk("pre_full", full_rows, 30'h2000_0028);
        do_clear(29, cycles);
        chk("c29_busy_cycles", cycles, 30);
        chk("c29_row29", board[29], 32'h9ABC_DEF0);
        chk("c29_row28", board[28], 32'h1234_5678);
        chk("c29_row27", board[27], 32'h0);
        chk("c29_row6", board[6], 32'h5555_5555);
        chk("c29_row4", board[4], 32'hFFFF_FFFF);
        chk("c29_row0", board[0], 32'h0);
        chk("c29_full", full_rows, 30'h50);

        // Mid-collapse write is dropped, then CLEAR_ALL aborts
        clear_req = 1; clear_row = 5'd20;
        cycle();
        clear_req = 0;
        chk("mid_busy", busy, 1);
        we = 1; addr = 11'd10; wdata = 32'hDEAD_BEEF;
        cycle();
        we = 0;
        chk("mid_we_drop", req_drop, 1);
        chk("mid_row10", board[10], 32'h0);
        clear_all = 1; re = 1; addr = 11'd0;
        cycle();
        idle_inputs();
        chk("ca_busy", busy, 0);
        chk("ca_drop", req_drop, 0);
        chk("ca_rvalid", rvalid, 0);
        chk("ca_rows", nonzero_rows(), 0);
        chk("ca_full", full_rows, 0);

        // Row 0 collapse takes one cycle
        write_row(0, 32'h1);
        write_row(1, 32'h2);
        do_clear(0, cycles);
        chk("c0_busy_cycles", cycles, 1);
        chk("c0_row0", board[0], 32'h0);
        chk("c0_row1", board[1], 32'h2);

        // Out-of-range clear row
        clear_req = 1; clear_row = 5'd30;
        cycle();
        clear_req = 0;
        chk("c30_drop", req_drop, 1);
        chk("c30_busy", busy, 0);
        cycle();
        chk("drop_pulse_end", req_drop, 0);

        write_row(0, 32'h11);
        write_row(1, 32'h22);
        write_row(2, 32'h33);
        do_clear(2, cycles);
        chk("c2_busy_cycles", cycles, 3);
        chk("c2_row2", board[2], 32'h22);
        chk("c2_row1", board[1], 32'h11);
        chk("c2_row0", board[0], 32'h0);
        do_clear(1, cycles);
        chk("c1_busy_cycles", cycles, 2);
        chk("c1_row1", board[1], 32'h0);
        chk("c1_row2", board[2], 32'h22);
`ifdef LINE_COUNT_EN
        chk("lines_3", lines, 3);
        clear_all = 1;
        cycle();
        clear_all = 0;
        chk("lines_ca", lines, 0);
`endif

        // Asynchronous reset in the middle of a shift
        write_row(15, 32'h7);
        clear_req = 1; clear_row = 5'd15;
        cycle();
        clear_req = 0;
        cycle();
        cycle();
        chk("rs_busy_before", busy, 1);
        #2 rst = 1;
        #1;
        chk("rs_busy", busy, 0);
        chk("rs_rows", nonzero_rows(), 0);
        chk("rs_rvalid", rvalid, 0);
        @(negedge clk);
        rst = 0;
        cycle();
        chk("rs_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
